// File: rtl/sump_cmd_ctrl.sv
// SUMP command decoder: updates capture configuration, pulses arm/soft-reset,
// and streams ID (and, with LOGIP_CMD_META_EN, metadata) bytes to the UART TX.
module sump_cmd_ctrl #(
  parameter logic [31:0] ID_WORD = 32'h31414C53,
  parameter int          DIV_W   = 24,
  parameter int          CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic [39:0]       cmd_i,
  input  logic              stb_i,
  output logic              arm_o,
  output logic              srst_o,
  output logic [31:0]       trg_mask_o,
  output logic [31:0]       trg_val_o,
  output logic [31:0]       trg_cfg_o,
  output logic [DIV_W-1:0]  div_o,
  output logic [CNT_W-1:0]  read_cnt_o,
  output logic [CNT_W-1:0]  delay_cnt_o,
  output logic [7:0]        flags_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_stb_o,
  input  logic              tx_rdy_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
`ifdef LOGIP_CMD_META_EN
    SEND_META = 2'd2,
`endif
    SEND_ID   = 2'd1
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        last_idx_s;
  logic              arm_q, arm_d;
  logic              srst_q, srst_d;
  logic [31:0]       trg_mask_q, trg_mask_d;
  logic [31:0]       trg_val_q, trg_val_d;
  logic [31:0]       trg_cfg_q, trg_cfg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  read_cnt_q, read_cnt_d;
  logic [CNT_W-1:0]  delay_cnt_q, delay_cnt_d;
  logic [7:0]        flags_q, flags_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_stb_q, tx_stb_d;
  logic [7:0]        opcode_s;
  logic [31:0]       payload_s;

  assign opcode_s  = cmd_i[7:0];
  assign payload_s = cmd_i[39:8];

  function automatic logic [7:0] id_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    id_byte = ID_WORD[31:24];
      3'd1:    id_byte = ID_WORD[23:16];
      3'd2:    id_byte = ID_WORD[15:8];
      3'd3:    id_byte = ID_WORD[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

`ifdef LOGIP_CMD_META_EN
  function automatic logic [7:0] meta_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    meta_byte = 8'h01;
      3'd1:    meta_byte = 8'h6C;
      3'd2:    meta_byte = 8'h6F;
      3'd3:    meta_byte = 8'h67;
      3'd4:    meta_byte = 8'h49;
      3'd5:    meta_byte = 8'h50;
      default: meta_byte = 8'h00;
    endcase
  endfunction
`endif

  // Next-state: byte sequencing first, then command decode (soft reset overrides).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    arm_d       = 1'b0;
    srst_d      = 1'b0;
    trg_mask_d  = trg_mask_q;
    trg_val_d   = trg_val_q;
    trg_cfg_d   = trg_cfg_q;
    div_d       = div_q;
    read_cnt_d  = read_cnt_q;
    delay_cnt_d = delay_cnt_q;
    flags_d     = flags_q;
    tx_data_d   = 8'h00;
    tx_stb_d    = 1'b0;

    case (state_q)
`ifdef LOGIP_CMD_META_EN
      SEND_META: last_idx_s = 3'd7;
`endif
      default:   last_idx_s = 3'd3;
    endcase

    if (tx_stb_q && tx_rdy_i) begin
      if (idx_q == last_idx_s) begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      idx_d = idx_q;
    end

    if (stb_i) begin
      case (opcode_s)
        8'h00: begin
          srst_d      = 1'b1;
          state_d     = IDLE;
          idx_d       = 3'd0;
          trg_mask_d  = 32'h0;
          trg_val_d   = 32'h0;
          trg_cfg_d   = 32'h0;
          div_d       = '0;
          read_cnt_d  = '0;
          delay_cnt_d = '0;
          flags_d     = 8'h00;
        end
        8'h01: arm_d = 1'b1;
        8'h02: begin
          if (state_q == IDLE) begin
            state_d = SEND_ID;
            idx_d   = 3'd0;
          end else begin
            state_d = state_d;
          end
        end
`ifdef LOGIP_CMD_META_EN
        8'h04: begin
          if (state_q == IDLE) begin
            state_d = SEND_META;
            idx_d   = 3'd0;
          end else begin
            state_d = state_d;
          end
        end
`endif
        8'hC0:   trg_mask_d  = payload_s;
        8'hC1:   trg_val_d   = payload_s;
        8'hC2:   trg_cfg_d   = payload_s;
        8'h80:   div_d       = payload_s[DIV_W-1:0];
        8'h81: begin
          read_cnt_d  = payload_s[CNT_W-1:0];
          delay_cnt_d = payload_s[16 +: CNT_W];
        end
        8'h82:   flags_d     = payload_s[7:0];
        default: arm_d       = 1'b0;
      endcase
    end else begin
      arm_d = 1'b0;
    end

    // Response byte is registered from the next state so tx_data_o never glitches.
    case (state_d)
      SEND_ID:   tx_data_d = id_byte(idx_d);
`ifdef LOGIP_CMD_META_EN
      SEND_META: tx_data_d = meta_byte(idx_d);
`endif
      default:   tx_data_d = 8'h00;
    endcase
    tx_stb_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      arm_q       <= 1'b0;
      srst_q      <= 1'b0;
      trg_mask_q  <= 32'h0;
      trg_val_q   <= 32'h0;
      trg_cfg_q   <= 32'h0;
      div_q       <= '0;
      read_cnt_q  <= '0;
      delay_cnt_q <= '0;
      flags_q     <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_stb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arm_q       <= arm_d;
      srst_q      <= srst_d;
      trg_mask_q  <= trg_mask_d;
      trg_val_q   <= trg_val_d;
      trg_cfg_q   <= trg_cfg_d;
      div_q       <= div_d;
      read_cnt_q  <= read_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      flags_q     <= flags_d;
      tx_data_q   <= tx_data_d;
      tx_stb_q    <= tx_stb_d;
    end
  end

  assign arm_o       = arm_q;
  assign srst_o      = srst_q;
  assign trg_mask_o  = trg_mask_q;
  assign trg_val_o   = trg_val_q;
  assign trg_cfg_o   = trg_cfg_q;
  assign div_o       = div_q;
  assign read_cnt_o  = read_cnt_q;
  assign delay_cnt_o = delay_cnt_q;
  assign flags_o     = flags_q;
  assign tx_data_o   = tx_data_q;
  assign tx_stb_o    = tx_stb_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// Directed self-checking bench for sump_cmd_ctrl (metadata checks follow LOGIP_CMD_META_EN).
module tb_sump_cmd_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic [39:0] cmd_i;
  logic        stb_i;
  logic        arm_o, srst_o;
  logic [31:0] trg_mask_o, trg_val_o, trg_cfg_o;
  logic [23:0] div_o;
  logic [15:0] read_cnt_o, delay_cnt_o;
  logic [7:0]  flags_o, tx_data_o;
  logic        tx_stb_o, tx_rdy_i, busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  sump_cmd_ctrl dut (
    .clk_i(clk_i), .rst_in(rst_in), .cmd_i(cmd_i), .stb_i(stb_i),
    .arm_o(arm_o), .srst_o(srst_o), .trg_mask_o(trg_mask_o),
    .trg_val_o(trg_val_o), .trg_cfg_o(trg_cfg_o), .div_o(div_o),
    .read_cnt_o(read_cnt_o), .delay_cnt_o(delay_cnt_o), .flags_o(flags_o),
    .tx_data_o(tx_data_o), .tx_stb_o(tx_stb_o), .tx_rdy_i(tx_rdy_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [39:0] c);
    cmd_i = c;
    stb_i = 1'b1;
    step();
    stb_i = 1'b0;
    cmd_i = 40'h0;
  endtask

  logic [7:0] id_bytes [4];
  logic [7:0] meta_bytes [8];

  initial begin
    int xfers;
    int hold_err;
    int seq_err;
    logic       prev_wait;
    logic [7:0] prev_data;

    id_bytes   = '{8'h31, 8'h41, 8'h4C, 8'h53};
    meta_bytes = '{8'h01, 8'h6C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h00, 8'h00};
    rst_in = 1'b0; stb_i = 1'b0; cmd_i = 40'h0; tx_rdy_i = 1'b0;
    #12;
    check("rst_div", 40'(div_o), 40'h0);
    check("rst_tx_stb", 40'(tx_stb_o), 40'h0);
    check("rst_busy", 40'(busy_o), 40'h0);
    step();
    rst_in = 1'b1;
    step();

    // Divider write; nothing else moves.
    send_cmd(40'h78563412_80);
    check("div", 40'(div_o), 40'h563412);
    check("div_mask", 40'(trg_mask_o), 40'h0);
    check("div_arm", 40'(arm_o), 40'h0);
    check("div_tx_stb", 40'(tx_stb_o), 40'h0);

    send_cmd(40'h00200010_81);
    check("read_cnt", 40'(read_cnt_o), 40'h0010);
    check("delay_cnt", 40'(delay_cnt_o), 40'h0020);

    send_cmd(40'h00000000_01);
    check("arm_pulse", 40'(arm_o), 40'h1);
    step();
    check("arm_clear", 40'(arm_o), 40'h0);

    send_cmd(40'h00000000_82 | 40'hA5_00);
    check("flags", 40'(flags_o), 40'hA5);

    // ID stream with the transmitter always ready.
    tx_rdy_i = 1'b1;
    send_cmd(40'h00000000_02);
    for (int i = 0; i < 4; i++) begin
      check("id_byte", 40'(tx_data_o), 40'(id_bytes[i]));
      check("id_stb", 40'(tx_stb_o), 40'h1);
      check("id_busy", 40'(busy_o), 40'h1);
      step();
    end
    check("id_done_busy", 40'(busy_o), 40'h0);
    check("id_done_stb", 40'(tx_stb_o), 40'h0);

    // ID stream with back-pressure and a duplicate 0x02 mid-sequence.
    tx_rdy_i = 1'b0;
    send_cmd(40'h00000000_02);
    xfers = 0; hold_err = 0; seq_err = 0; prev_wait = 1'b0; prev_data = 8'h00;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tx_rdy_i = ((cyc / 3) % 2) == 1;
      stb_i = (cyc == 5);
      cmd_i = (cyc == 5) ? 40'h00000000_02 : 40'h0;
      if (prev_wait && tx_stb_o && tx_data_o !== prev_data) hold_err++;
      if (tx_stb_o && tx_rdy_i) begin
        if (xfers > 3 || tx_data_o !== id_bytes[xfers & 3]) seq_err++;
        xfers++;
      end
      prev_wait = tx_stb_o && !tx_rdy_i;
      prev_data = tx_data_o;
      step();
    end
    stb_i = 1'b0; cmd_i = 40'h0;
    check("bp_xfers", 40'(xfers), 40'd4);
    check("bp_hold", 40'(hold_err), 40'd0);
    check("bp_order", 40'(seq_err), 40'd0);
    check("bp_idle", 40'(busy_o), 40'h0);

    // Config write during SEND_ID, then soft reset aborts the stream.
    tx_rdy_i = 1'b0;
    send_cmd(40'h00000000_02);
    send_cmd(40'hFFFF0000_C0);
    check("send_mask", 40'(trg_mask_o), 40'hFFFF0000);
    check("send_hold_data", 40'(tx_data_o), 40'h31);
    check("send_hold_stb", 40'(tx_stb_o), 40'h1);
    tx_rdy_i = 1'b1;
    step();
    check("send_continue", 40'(tx_data_o), 40'h41);
    send_cmd(40'h00000000_00);
    check("srst_pulse", 40'(srst_o), 40'h1);
    check("srst_stb", 40'(tx_stb_o), 40'h0);
    check("srst_busy", 40'(busy_o), 40'h0);
    check("srst_mask", 40'(trg_mask_o), 40'h0);
    check("srst_div", 40'(div_o), 40'h0);
    check("srst_read", 40'(read_cnt_o), 40'h0);
    check("srst_flags", 40'(flags_o), 40'h0);
    step();
    check("srst_clear", 40'(srst_o), 40'h0);

    // Asynchronous reset mid-stream.
    send_cmd(40'h12345678_C1);
    check("trg_val", 40'(trg_val_o), 40'h12345678);
    tx_rdy_i = 1'b0;
    send_cmd(40'h00000000_02);
    check("pre_rst_busy", 40'(busy_o), 40'h1);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_stb", 40'(tx_stb_o), 40'h0);
    check("arst_busy", 40'(busy_o), 40'h0);
    check("arst_data", 40'(tx_data_o), 40'h0);
    check("arst_val", 40'(trg_val_o), 40'h0);
    step();
    rst_in = 1'b1;
    step();

    // Metadata opcode.
    tx_rdy_i = 1'b1;
    send_cmd(40'h00000000_04);
`ifdef LOGIP_CMD_META_EN
    for (int i = 0; i < 8; i++) begin
      check("meta_byte", 40'(tx_data_o), 40'(meta_bytes[i]));
      check("meta_stb", 40'(tx_stb_o), 40'h1);
      step();
    end
    check("meta_done", 40'(busy_o), 40'h0);
`else
    for (int i = 0; i < 8; i++) begin
      check("no_meta_stb", 40'(tx_stb_o), 40'h0);
      check("no_meta_busy", 40'(busy_o), 40'h0);
      step();
    end
`endif

    // Ignored opcodes leave everything unchanged.
    send_cmd(40'hDEADBEEF_11);
    send_cmd(40'hDEADBEEF_C4);
    check("ign_mask", 40'(trg_mask_o), 40'h0);
    check("ign_busy", 40'(busy_o), 40'h0);
    check("ign_arm", 40'(arm_o), 40'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
